// File: rtl/cr_branch_eval.sv
// rtl/cr_branch_eval.sv - BO/BI branch-condition evaluator with CTR ownership and CR-writer scoreboard.
// Optional build macro: CR_BRANCH_BYPASS_EN (evaluate on cr_wd when the last awaited writer commits).
module cr_branch_eval #(
    parameter int CR_WIDTH  = 32,
    parameter int CR_DEPTH  = 5,
    parameter int CTR_WIDTH = 32,
    parameter int PEND_MAX  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CR_WIDTH-1:0]  cr_rd,
    input  logic                 cr_wr,
    input  logic [CR_WIDTH-1:0]  cr_wd,
    input  logic                 cr_issue,
    output logic                 cr_issue_ready,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4:0]           req_bo,
    input  logic [CR_DEPTH-1:0]  req_bi,
    input  logic                 ctr_wr,
    input  logic [CTR_WIDTH-1:0] ctr_wd,
    output logic [CTR_WIDTH-1:0] ctr_rd,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_taken
);

    localparam int PW = $clog2(PEND_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT_CR, RESP} state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        pend_cnt;
    logic [PW-1:0]        wait_cnt;
    logic [CTR_WIDTH-1:0] ctr_q;
    logic [CR_DEPTH-1:0]  bi_q;
    logic                 bo1_q;
    logic                 ctr_ok_q;
    logic                 taken_q;

    // BO is big-endian: BO[n] lives at req_bo[4-n]; BO[4] is a hint and ignored
    logic bo0, bo1, bo2, bo3;
    logic unused_hint;
    assign bo0 = req_bo[4];
    assign bo1 = req_bo[3];
    assign bo2 = req_bo[2];
    assign bo3 = req_bo[1];
    assign unused_hint = req_bo[0];

    logic accept;
    logic issue_acc, wr_acc;
    logic [CTR_WIDTH-1:0] ctr_m;
    logic ctr_ok_now;

    assign req_ready      = (state == IDLE) && !(ctr_wr && !bo2);
    assign accept         = req_valid && req_ready;
    assign cr_issue_ready = (pend_cnt != PW'(PEND_MAX));
    assign issue_acc      = cr_issue && cr_issue_ready;
    assign wr_acc         = cr_wr && (pend_cnt != '0);
    assign ctr_m          = bo2 ? ctr_q : (ctr_q - CTR_WIDTH'(1));
    assign ctr_ok_now     = bo2 || ((ctr_m != '0) ^ bo3);

    assign ctr_rd     = ctr_q;
    assign resp_valid = (state == RESP);
    assign resp_taken = (state == RESP) && taken_q;

    // CR bit 0 is the MSB, so shift the selected bit up to the top
    function automatic logic cr_bit(input logic [CR_WIDTH-1:0] cr, input logic [CR_DEPTH-1:0] bi);
        logic [CR_WIDTH-1:0] sh;
        sh = cr << bi;
        return sh[CR_WIDTH-1];
    endfunction

    logic                eval_en;
    logic                wait_load;
    logic [CR_WIDTH-1:0] eval_src;
    logic [CR_DEPTH-1:0] eval_bi;
    logic                eval_bo0;
    logic                eval_bo1;
    logic                eval_ctr_ok;
    logic                taken_nxt;

    always_comb begin
        state_nxt   = state;
        eval_en     = 1'b0;
        wait_load   = 1'b0;
        eval_src    = cr_rd;
        eval_bi     = req_bi;
        eval_bo0    = bo0;
        eval_bo1    = bo1;
        eval_ctr_ok = ctr_ok_now;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bo0 || (pend_cnt == '0)) begin
                        state_nxt = RESP;
                        eval_en   = 1'b1;
                    end
`ifdef CR_BRANCH_BYPASS_EN
                    else if ((pend_cnt == PW'(1)) && cr_wr) begin
                        state_nxt = RESP;
                        eval_en   = 1'b1;
                        eval_src  = cr_wd;
                    end
`endif
                    else begin
                        state_nxt = WAIT_CR;
                        wait_load = 1'b1;
                    end
                end
            end
            WAIT_CR: begin
                eval_bi     = bi_q;
                eval_bo0    = 1'b0;
                eval_bo1    = bo1_q;
                eval_ctr_ok = ctr_ok_q;
                if (wait_cnt == '0) begin
                    state_nxt = RESP;
                    eval_en   = 1'b1;
                end
`ifdef CR_BRANCH_BYPASS_EN
                else if (cr_wr && (wait_cnt == PW'(1))) begin
                    state_nxt = RESP;
                    eval_en   = 1'b1;
                    eval_src  = cr_wd;
                end
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        taken_nxt = eval_ctr_ok && (eval_bo0 || (cr_bit(eval_src, eval_bi) == eval_bo1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outstanding CR writers; a simultaneous issue and commit cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt <= '0;
        end else if (issue_acc && !wr_acc) begin
            pend_cnt <= pend_cnt + PW'(1);
        end else if (wr_acc && !issue_acc) begin
            pend_cnt <= pend_cnt - PW'(1);
        end
    end

    // A decrementing branch and an mtctr never share a cycle (req_ready blocks it)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q <= '0;
        end else if (accept && !bo2) begin
            ctr_q <= ctr_m;
        end else if (ctr_wr) begin
            ctr_q <= ctr_wd;
        end
    end

    // Only writers older than the branch are counted; younger issues never touch wait_cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            bi_q     <= '0;
            bo1_q    <= 1'b0;
            ctr_ok_q <= 1'b0;
        end else if (wait_load) begin
            wait_cnt <= pend_cnt - {{(PW-1){1'b0}}, cr_wr};
            bi_q     <= req_bi;
            bo1_q    <= bo1;
            ctr_ok_q <= ctr_ok_now;
        end else if ((state == WAIT_CR) && cr_wr && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q <= 1'b0;
        end else if (eval_en) begin
            taken_q <= taken_nxt;
        end
    end

endmodule

// File: tb/tb_cr_branch_eval.sv
// tb/tb_cr_branch_eval.sv - self-checking bench for cr_branch_eval against a BO/BI/CTR rule model.
module tb_cr_branch_eval;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cr_rd;
    logic        cr_wr;
    logic [31:0] cr_wd;
    logic        cr_issue;
    logic        cr_issue_ready;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_bo;
    logic [4:0]  req_bi;
    logic        ctr_wr;
    logic [31:0] ctr_wd;
    logic [31:0] ctr_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_taken;

    int n_chk = 0;
    int n_err = 0;

    cr_branch_eval dut (
        .clk(clk), .rst_n(rst_n), .cr_rd(cr_rd), .cr_wr(cr_wr), .cr_wd(cr_wd),
        .cr_issue(cr_issue), .cr_issue_ready(cr_issue_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_bo(req_bo), .req_bi(req_bi),
        .ctr_wr(ctr_wr), .ctr_wd(ctr_wd), .ctr_rd(ctr_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_taken(resp_taken)
    );

    always #5 clk = ~clk;

    // Branch outcome from the architectural rules; bo is written BO[0..4] = bo[4..0]
    function automatic bit model_taken(input logic [4:0] bo, input int bi, input logic [31:0] cr, input logic [31:0] ctr);
        longint cm;
        bit ctr_ok, crbit, cond_ok;
        cm      = bo[2] ? longint'(ctr) : (ctr == 0 ? 64'hFFFF_FFFF : longint'(ctr) - 1);
        ctr_ok  = bo[2] || ((cm != 0) != bo[1]);
        crbit   = ((cr >> (31 - bi)) & 32'd1) != 0;
        cond_ok = bo[4] || (crbit == bo[3]);
        return ctr_ok && cond_ok;
    endfunction

    function automatic logic [31:0] model_ctr(input logic [4:0] bo, input logic [31:0] ctr);
        longint v;
        v = bo[2] ? longint'(ctr) : (longint'(ctr) + 64'hFFFF_FFFF) % 64'h1_0000_0000;
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (cr_wr) cr_rd = cr_wd;
        cr_wr    = 1'b0;
        cr_issue = 1'b0;
        ctr_wr   = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cr_rd = '0; cr_wr = 0; cr_wd = '0; cr_issue = 0;
        req_valid = 0; req_bo = '0; req_bi = '0; ctr_wr = 0; ctr_wd = '0; resp_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (resp_valid !== 1'b0 || resp_taken !== 1'b0) begin n_err++; $display("FAIL reset_resp: got %b%b want 00", resp_valid, resp_taken); end
        n_chk++; if (req_ready !== 1'b1 || cr_issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b%b want 11", req_ready, cr_issue_ready); end
        n_chk++; if (ctr_rd !== 32'd0) begin n_err++; $display("FAIL reset_ctr: got %h want 0", ctr_rd); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ctr_bdnz();
        logic [31:0] cm;
        bit exp_t;
        ctr_wr = 1; ctr_wd = 32'd3;
        tick();
        cm = 32'd3;
        n_chk++; if (ctr_rd !== cm) begin n_err++; $display("FAIL mtctr_load: got %h want %h", ctr_rd, cm); end
        for (int k = 0; k < 3; k++) begin
            req_valid = 1; req_bo = 5'b10000; req_bi = 5'd0;
            exp_t = model_taken(5'b10000, 0, cr_rd, cm);
            cm = model_ctr(5'b10000, cm);
            tick();
            req_valid = 0;
            n_chk++; if (resp_valid !== 1'b1 || resp_taken !== exp_t) begin n_err++; $display("FAIL bdnz_%0d_resp: got v=%b t=%b want v=1 t=%b", k, resp_valid, resp_taken, exp_t); end
            n_chk++; if (ctr_rd !== cm) begin n_err++; $display("FAIL bdnz_%0d_ctr: got %h want %h", k, ctr_rd, cm); end
            tick();
        end
    endtask

    task automatic test_cr_cond();
        logic [31:0] ctr0;
        bit exp_t;
        cr_rd = 32'h8000_0000;
        ctr0 = ctr_rd;
        for (int b = 0; b < 2; b++) begin
            req_valid = 1; req_bo = 5'b01100; req_bi = 5'(b);
            exp_t = model_taken(5'b01100, b, cr_rd, ctr0);
            tick();
            req_valid = 0;
            n_chk++; if (resp_valid !== 1'b1 || resp_taken !== exp_t) begin n_err++; $display("FAIL beq_bi%0d: got v=%b t=%b want v=1 t=%b", b, resp_valid, resp_taken, exp_t); end
            n_chk++; if (ctr_rd !== ctr0) begin n_err++; $display("FAIL beq_bi%0d_ctr: got %h want %h", b, ctr_rd, ctr0); end
            tick();
        end
    endtask

    task automatic test_wait();
        int lat;
        int exp_lat;
`ifdef CR_BRANCH_BYPASS_EN
        exp_lat = 1;
`else
        exp_lat = 2;
`endif
        cr_rd = 32'h0;
        repeat (2) begin cr_issue = 1; tick(); end
        req_valid = 1; req_bo = 5'b01100; req_bi = 5'd2;
        tick();
        req_valid = 0;
        n_chk++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL wait_enter: got v=%b rdy=%b want v=0 rdy=0", resp_valid, req_ready); end
        cr_issue = 1; tick();
        tick();
        cr_wr = 1; cr_wd = 32'h0; tick();
        n_chk++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL wait_after_wr1: got %b want 0", resp_valid); end
        cr_wr = 1; cr_wd = 32'h2000_0000; tick();
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        n_chk++; if (lat !== exp_lat) begin n_err++; $display("FAIL wait_latency: got %0d want %0d", lat, exp_lat); end
        n_chk++; if (resp_taken !== 1'b1) begin n_err++; $display("FAIL wait_taken: got %b want 1", resp_taken); end
        tick();
        cr_wr = 1; cr_wd = 32'h2000_0000; tick();
        n_chk++; if (req_ready !== 1'b1 || cr_issue_ready !== 1'b1) begin n_err++; $display("FAIL wait_drain: got rdy=%b iss=%b want 11", req_ready, cr_issue_ready); end
    endtask

    task automatic test_backpressure();
        resp_ready = 0;
        req_valid = 1; req_bo = 5'b10100; req_bi = 5'd7;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_chk++; if (resp_valid !== 1'b1 || resp_taken !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL stall_%0d: got v=%b t=%b rdy=%b want 1 1 0", k, resp_valid, resp_taken, req_ready); end
            tick();
        end
        req_valid = 0;
        resp_ready = 1;
        tick();
        n_chk++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: got v=%b rdy=%b want 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_ctr_wrap();
        ctr_wr = 1; ctr_wd = 32'd0; tick();
        req_valid = 1; req_bo = 5'b10010; req_bi = 5'd0;
        tick();
        req_valid = 0;
        n_chk++; if (resp_valid !== 1'b1 || resp_taken !== 1'b0) begin n_err++; $display("FAIL bdz_wrap_resp: got v=%b t=%b want 1 0", resp_valid, resp_taken); end
        n_chk++; if (ctr_rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL bdz_wrap_ctr: got %h want ffffffff", ctr_rd); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] cm;
        logic [4:0]  bo;
        logic [4:0]  bi;
        logic [31:0] wd;
        bit          cw;
        bit          blocked;
        bit          exp_t;
        int          stall;
        ctr_wr = 1; ctr_wd = 32'd5; tick();
        cm = 32'd5;
        for (int it = 0; it < 40; it++) begin
            cr_rd = $urandom;
            bo = 5'($urandom);
            bi = 5'($urandom);
            cw = ($urandom_range(0, 3) == 0);
            wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2)) : $urandom;
            if ($urandom_range(0, 2) == 0) begin
                cm = 32'($urandom_range(0, 2));
                ctr_wr = 1; ctr_wd = cm; tick();
            end
            ctr_wr = cw; ctr_wd = wd;
            req_valid = 1; req_bo = bo; req_bi = bi;
            #1;
            blocked = cw && !bo[2];
            n_chk++; if (req_ready !== !blocked) begin n_err++; $display("FAIL rnd%0d_ready: got %b want %b", it, req_ready, !blocked); end
            if (blocked) begin
                tick();
                cm = wd;
                n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rnd%0d_unblock: got %b want 1", it, req_ready); end
            end
            exp_t = model_taken(bo, int'(bi), cr_rd, cm);
            cm = model_ctr(bo, cm);
            if (ctr_wr && bo[2]) cm = wd;
            tick();
            req_valid = 0;
            n_chk++; if (resp_valid !== 1'b1 || resp_taken !== exp_t) begin n_err++; $display("FAIL rnd%0d_resp: bo=%b bi=%0d got v=%b t=%b want v=1 t=%b", it, bo, bi, resp_valid, resp_taken, exp_t); end
            n_chk++; if (ctr_rd !== cm) begin n_err++; $display("FAIL rnd%0d_ctr: got %h want %h", it, ctr_rd, cm); end
            stall = $urandom_range(0, 2);
            resp_ready = (stall == 0);
            for (int s = 0; s < stall; s++) begin
                tick();
                n_chk++; if (resp_valid !== 1'b1 || resp_taken !== exp_t) begin n_err++; $display("FAIL rnd%0d_hold: got v=%b t=%b want v=1 t=%b", it, resp_valid, resp_taken, exp_t); end
            end
            resp_ready = 1;
            tick();
            n_chk++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rnd%0d_done: got %b want 0", it, resp_valid); end
        end
    endtask

    task automatic test_full_and_reset();
        cr_rd = 32'h0;
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (cr_issue_ready !== (i < 7)) begin n_err++; $display("FAIL full_ready_%0d: got %b want %b", i, cr_issue_ready, (i < 7)); end
            cr_issue = 1; tick();
        end
        n_chk++; if (cr_issue_ready !== 1'b0) begin n_err++; $display("FAIL full_after_8th: got %b want 0", cr_issue_ready); end
        req_valid = 1; req_bo = 5'b01100; req_bi = 5'd0;
        tick();
        req_valid = 0;
        for (int k = 0; k < 6; k++) begin
            cr_wr = 1; cr_wd = 32'h8000_0000; tick();
            n_chk++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL full_wait_%0d: got %b want 0", k, resp_valid); end
        end
        tick();
        n_chk++; if (resp_valid !== 1'b0 || cr_issue_ready !== 1'b1) begin n_err++; $display("FAIL full_one_left: got v=%b iss=%b want 0 1", resp_valid, cr_issue_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (resp_valid !== 1'b0 || resp_taken !== 1'b0 || req_ready !== 1'b1 || cr_issue_ready !== 1'b1 || ctr_rd !== 32'd0) begin
            n_err++; $display("FAIL async_reset: got v=%b t=%b rdy=%b iss=%b ctr=%h want 0 0 1 1 0", resp_valid, resp_taken, req_ready, cr_issue_ready, ctr_rd);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
        req_valid = 1; req_bo = 5'b01100; req_bi = 5'd0;
        tick();
        req_valid = 0;
        n_chk++; if (resp_valid !== 1'b1 || resp_taken !== 1'b1) begin n_err++; $display("FAIL post_reset_direct: got v=%b t=%b want 1 1", resp_valid, resp_taken); end
        tick();
    endtask

    initial begin
        test_reset();
        test_ctr_bdnz();
        test_cr_cond();
        test_wait();
        test_backpressure();
        test_ctr_wrap();
        test_random();
        test_full_and_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
